fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_wr_arbiter.sv | 129 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-aware arbiter that shares one FIFO write port among NUM_REQ requesters.
// Packets stay contiguous up to MAX_BURST beats; the lock is then force-released (trunc pulse).
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 8,
   parameter int SRC_W      = $clog2(NUM_REQ)
) (
   input  logic                          wclk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_last,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          full,
   output logic                          winc,
   output logic [DATA_WIDTH-1:0]         wdata,
   output logic [SRC_W-1:0]              wsrc,
   output logic                          busy,
   output logic                          trunc
);

   localparam int BEAT_W = $clog2(MAX_BURST + 1);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t            state_reg, state_next;
   logic [SRC_W-1:0]  rr_ptr_reg, rr_ptr_next;
   logic [SRC_W-1:0]  owner_reg, owner_next;
   logic [BEAT_W-1:0] beats_reg, beats_next;
   logic              trunc_reg, trunc_next;

   logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
   logic                  found;
   logic [SRC_W-1:0]      grant;
   logic [SRC_W-1:0]      grant_inc;
   logic [SRC_W-1:0]      sel;
   logic                  sel_valid;
   logic                  eligible;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
         assign data_arr[gi]  = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
         assign req_ready[gi] = eligible & (sel == SRC_W'(gi));
      end
   endgenerate

   // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin : search_blk
      int               cand_i;
      logic [SRC_W-1:0] cand;
      found  = 1'b0;
      grant  = '0;
      cand_i = 0;
      cand   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand_i = int'(rr_ptr_reg) + k;
         if (cand_i >= NUM_REQ) cand_i = cand_i - NUM_REQ;
         cand = SRC_W'(cand_i);
         if (!found && req_valid[cand]) begin
            found = 1'b1;
            grant = cand;
         end
      end
   end

   assign grant_inc = (grant == SRC_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
   assign sel       = (state_reg == LOCKED) ? owner_reg : grant;
   assign sel_valid = (state_reg == LOCKED) ? req_valid[owner_reg] : found;

   // In LOCKED the owner sees ready whenever the FIFO has room, even during a bubble.
   assign eligible  = rst_n & ~full & ((state_reg == LOCKED) | found);
   assign winc      = eligible & sel_valid;
   assign wdata     = data_arr[sel];
   assign wsrc      = sel;
   assign busy      = (state_reg == LOCKED);
   assign trunc     = trunc_reg;

   always_comb begin
      state_next  = state_reg;
      rr_ptr_next = rr_ptr_reg;
      owner_next  = owner_reg;
      beats_next  = beats_reg;
      trunc_next  = 1'b0;
      if (winc) begin
         case (state_reg)
            IDLE: begin
               rr_ptr_next = grant_inc;
               if (!req_last[grant] && (MAX_BURST > 1)) begin
                  state_next = LOCKED;
                  owner_next = grant;
                  beats_next = BEAT_W'(1);
               end
            end
            LOCKED: begin
               if (req_last[owner_reg]) begin
                  state_next = IDLE;
                  beats_next = '0;
               end else if (beats_reg + 1'b1 == BEAT_W'(MAX_BURST)) begin
                  state_next = IDLE;
                  beats_next = '0;
                  trunc_next = 1'b1;
               end else begin
                  beats_next = beats_reg + 1'b1;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge wclk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         rr_ptr_reg <= '0;
         owner_reg  <= '0;
         beats_reg  <= '0;
         trunc_reg  <= 1'b0;
      end else begin
         state_reg  <= state_next;
         rr_ptr_reg <= rr_ptr_next;
         owner_reg  <= owner_next;
         beats_reg  <= beats_next;
         trunc_reg  <= trunc_next;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed testbench for fifo_wr_arbiter: round robin, packet locking, forced release,
// full back-pressure, owner bubbles and reset while locked.
module tb_fifo_wr_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int MB = 8;
   localparam int SW = 2;

   logic            wclk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_last;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic            full;
   logic            winc;
   logic [DW-1:0]   wdata;
   logic [SW-1:0]   wsrc;
   logic            busy;
   logic            trunc;

   int checks = 0;
   int passes = 0;

   always #5 wclk = ~wclk;

   fifo_wr_arbiter #(
      .NUM_REQ   (N),
      .DATA_WIDTH(DW),
      .MAX_BURST (MB),
      .SRC_W     (SW)
   ) dut (
      .wclk     (wclk),
      .rst_n    (rst_n),
      .req_valid(req_valid),
      .req_last (req_last),
      .req_data (req_data),
      .req_ready(req_ready),
      .full     (full),
      .winc     (winc),
      .wdata    (wdata),
      .wsrc     (wsrc),
      .busy     (busy),
      .trunc    (trunc)
   );

   always @(negedge wclk) begin
      if (winc === 1'b1)
         $display("beat src=%0d data=%h busy=%0b", wsrc, wdata, busy);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge wclk);
      #1;
   endtask

   // Expect one accepted beat from src this cycle, then advance a clock.
   task automatic beat(input string tag, input int src, input logic exp_busy);
      logic [7:0] exp_data;
      exp_data = 8'hA0 + 8'(src);
      #1;
      check({tag, "_winc"},  32'(winc),      32'd1);
      check({tag, "_wsrc"},  32'(wsrc),      32'(src));
      check({tag, "_wdata"}, 32'(wdata),     32'(exp_data));
      check({tag, "_ready"}, 32'(req_ready), 32'd1 << src);
      check({tag, "_busy"},  32'(busy),      32'(exp_busy));
      tick();
   endtask

   task automatic idle_cycle(input string tag, input logic [N-1:0] exp_ready, input logic exp_busy);
      #1;
      check({tag, "_winc"},  32'(winc),      32'd0);
      check({tag, "_ready"}, 32'(req_ready), 32'(exp_ready));
      check({tag, "_busy"},  32'(busy),      32'(exp_busy));
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      req_valid = '1;
      req_last  = '1;
      full      = 1'b0;
      req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      #2;
      check("rst_winc",  32'(winc),      32'd0);
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_busy",  32'(busy),      32'd0);
      check("rst_trunc", 32'(trunc),     32'd0);
      tick();
      tick();
      rst_n = 1'b1;

      // All requesters with single-beat packets: strict rotation.
      for (int i = 0; i < 8; i++) beat("rr", i % 4, 1'b0);

      // Three-beat packet from req1 while req0/req2 also request.
      req_valid = 4'b0001;
      beat("pre2", 0, 1'b0);
      req_valid = 4'b0111;
      req_last  = 4'b1101;
      beat("pkt_b1", 1, 1'b0);
      beat("pkt_b2", 1, 1'b1);
      req_last  = 4'b1111;
      beat("pkt_b3", 1, 1'b1);
      beat("after_pkt", 2, 1'b0);

      // req2 streams without last: forced release after MB beats.
      req_valid = 4'b0010;
      beat("pre3", 1, 1'b0);
      req_valid = 4'b1100;
      req_last  = 4'b1011;
      for (int i = 0; i < MB; i++) begin
         check("burst_trunc", 32'(trunc), 32'd0);
         beat("burst", 2, i != 0);
      end
      check("trunc_pulse", 32'(trunc), 32'd1);
      beat("after_trunc", 3, 1'b0);
      check("trunc_clear", 32'(trunc), 32'd0);
      beat("resume1", 2, 1'b0);
      beat("resume2", 2, 1'b1);
      beat("resume3", 2, 1'b1);
      req_last = 4'b1111;
      beat("resume4", 2, 1'b1);

      // Full back-pressure mid-packet; beat count must survive the stall.
      req_valid = 4'b0011;
      req_last  = 4'b1110;
      beat("fpk_b1", 0, 1'b0);
      beat("fpk_b2", 0, 1'b1);
      full = 1'b1;
      for (int i = 0; i < 5; i++) idle_cycle("full_hold", 4'b0000, 1'b1);
      full = 1'b0;
      for (int i = 0; i < 6; i++) begin
         check("fpk_trunc", 32'(trunc), 32'd0);
         beat("fpk_cont", 0, 1'b1);
      end
      check("fpk_trunc_pulse", 32'(trunc), 32'd1);
      beat("post_fpk", 1, 1'b0);

      // Owner bubble: req3 drops valid while locked, req1 must be ignored.
      req_valid = 4'b1010;
      req_last  = 4'b0111;
      beat("own_b1", 3, 1'b0);
      beat("own_b2", 3, 1'b1);
      req_valid = 4'b0010;
      idle_cycle("bubble", 4'b1000, 1'b1);
      idle_cycle("bubble", 4'b1000, 1'b1);
      req_valid = 4'b1010;
      req_last  = 4'b1111;
      beat("own_b3", 3, 1'b1);
      beat("after_own", 1, 1'b0);

      // Reset asserted while req2 holds the lock with four beats written.
      req_valid = 4'b0100;
      req_last  = 4'b1011;
      for (int i = 0; i < 4; i++) beat("lk", 2, i != 0);
      check("lk_busy", 32'(busy), 32'd1);
      req_valid = 4'b0101;
      rst_n     = 1'b0;
      #1;
      check("mid_rst_winc",  32'(winc),      32'd0);
      check("mid_rst_ready", 32'(req_ready), 32'd0);
      check("mid_rst_busy",  32'(busy),      32'd0);
      tick();
      rst_n    = 1'b1;
      req_last = 4'b1111;
      beat("post_rst", 0, 1'b0);
      beat("post_rst2", 2, 1'b0);
      req_valid = '0;
      idle_cycle("drain", 4'b0000, 1'b0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
